// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_ZERO = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush empties it and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_din,
    output fetch_entry_t o_dout,
    output logic [AW:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, combinational imem read, and a decoupled
// instruction stream with redirect/flush, halt-on-zero and misalign error.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misalign_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_pc;
    logic          r_halted;
    logic          r_err;

    fetch_entry_t  w_head;
    fetch_entry_t  w_din;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_flush;
    logic          w_pop;
    logic          w_fetch;
    logic          w_push;

    assign w_flush   = redirect_valid && (r_state != ST_ERR);
    assign out_valid = !w_empty && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign w_fetch   = (r_state == ST_RUN) && !redirect_valid &&
                       ((w_count < CW'(DEPTH)) || (w_full && w_pop));
    assign w_push    = w_fetch && (imem_instr != NOP_ZERO);
    assign w_din     = '{pc: r_pc, instr: imem_instr};

    assign imem_addr    = r_pc;
    assign out_instr    = w_empty ? 32'h0 : w_head.instr;
    assign out_pc       = w_empty ? 32'h0 : w_head.pc;
    assign halted       = r_halted;
    assign misalign_err = r_err;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_HALT: begin
                    if (redirect_valid) begin
                        r_halted <= 1'b0;
                        if (redirect_pc[1:0] == 2'b00) begin
                            r_pc    <= redirect_pc;
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_fetch) begin
                        // An all-zero word stops fetch with the PC parked on it.
                        if (imem_instr == NOP_ZERO) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + PC_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h00A0_0113;
    localparam logic [31:0] IT = 32'h04D0_0613;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misalign_err;

    logic [31:0] mem [64];
    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] eaddr;
        logic        eh;
        logic        ee;
    } vec_t;

    vec_t tbl [40];
    int   nvec;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 | 32'(i);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic [31:0] eaddr, input logic eh, input logic ee);
        tbl[nvec] = '{r, rdy, rv, rpc, ev, epc, ein, eaddr, eh, ee};
        nvec++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;
        for (int i = 0; i < 64; i++) mem[i] = (i >= 2 && i <= 20) ? w(i) : 32'h0;
        mem[0]  = I0;
        mem[1]  = I1;
        mem[13] = IT;
        mem[63] = w(63);

        //   rst rdy rv rpc        | v  pc         instr  addr       h  e
        add(1, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h0,  0, 0);  // reset state
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h0,  0, 0);  // first fetch
        add(0, 1, 0, 32'h0,        1, 32'h0,  I0,    32'h4,  0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h4,  I1,    32'h8,  0, 0);
        add(0, 0, 0, 32'h0,        1, 32'h8,  w(2),  32'hC,  0, 0);  // backpressure
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 32'h0,    1, 32'h8,  w(2),  32'h10, 0, 0);  // full, pc stalls
        add(0, 1, 0, 32'h0,        1, 32'h8,  w(2),  32'h10, 0, 0);  // release
        add(0, 1, 0, 32'h0,        1, 32'hC,  w(3),  32'h14, 0, 0);
        add(0, 1, 1, 32'h34,       0, 32'h10, w(4),  32'h18, 0, 0);  // redirect on full
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h34, 0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h34, IT,    32'h38, 0, 0);
        add(0, 1, 1, 32'h4C,       0, 32'h38, w(14), 32'h3C, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h4C, 0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h4C, w(19), 32'h50, 0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h50, w(20), 32'h54, 0, 0);  // zero word fetched
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h54, 1, 0);  // halted
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h54, 1, 0);
        add(0, 1, 1, 32'h0,        0, 32'h0,  32'h0, 32'h54, 1, 0);  // redirect out of halt
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h0,  0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h0,  I0,    32'h4,  0, 0);
        add(0, 1, 1, 32'h6,        0, 32'h4,  I1,    32'h8,  0, 0);  // misaligned
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h8,  0, 1);
        add(0, 1, 1, 32'h0,        0, 32'h0,  32'h0, 32'h8,  0, 1);  // ignored in ERR
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h8,  0, 1);
        add(1, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h8,  0, 1);  // rst clears ERR
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,        1, 32'h0,  I0,    32'h4,  0, 0);
        add(0, 0, 0, 32'h0,        1, 32'h0,  I0,    32'h8,  0, 0);  // two entries held
        add(1, 0, 0, 32'h0,        1, 32'h0,  I0,    32'h8,  0, 0);  // reset mid-stream
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0, 32'h0,  0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h0,  I0,    32'h4,  0, 0);

        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            check("out_valid",    i, 32'(out_valid),    32'(tbl[i].ev));
            check("imem_addr",    i, imem_addr,         tbl[i].eaddr);
            check("halted",       i, 32'(halted),       32'(tbl[i].eh));
            check("misalign_err", i, 32'(misalign_err), 32'(tbl[i].ee));
            check("out_pc",       i, out_pc,            tbl[i].epc);
            check("out_instr",    i, out_instr,         tbl[i].ein);
        end

        // PC wrap: redirect to the last word, then the fetch wraps to 0.
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_rv_valid", 100, 32'(out_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", 101, imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check("wrap_addr1", 102, imem_addr, 32'h0);
        check("wrap_pc",    103, out_pc,    32'hFFFF_FFFC);
        check("wrap_instr", 104, out_instr, w(63));

        // Run into the zero word again, bounded wait on halted.
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h4C;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 20 && !halted; k++) @(negedge clk);
        #1;
        check("halt_reached", 105, 32'(halted),   32'h1);
        check("halt_addr",    106, imem_addr,     32'h54);
        check("halt_empty",   107, 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that drives the address side of the instruction memory and feeds a decoupled instruction stream to decode. It holds the PC and reads one word per cycle from the combinational instruction memory. Each fetched instruction is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It supports branch/jump redirects with a flush, halts on an all-zero word, and latches a sticky error on a misaligned redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word aligned.
- DEPTH, 2: FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- imem_addr, output, 32: byte address to the instruction memory; always equals the PC register.
- imem_instr, input, 32: instruction word from the memory, valid in the same cycle as imem_addr (combinational read).
- out_valid, output, 1: FIFO head holds an instruction.
- out_ready, input, 1: decode accepts the head this cycle.
- out_instr, output, 32: instruction at the FIFO head.
- out_pc, output, 32: PC of out_instr.
- redirect_valid, input, 1: taken branch or jump this cycle.
- redirect_pc, input, 32: redirect target.
- halted, output, 1: the unit is in the HALT state.
- misalign_err, output, 1: the unit is in the ERR state (sticky).

## Operation
- States are RUN, HALT and ERR. Reset puts the unit in RUN with pc=RESET_PC and count=0.
- Reset values: out_valid=0, halted=0, misalign_err=0, imem_addr=RESET_PC. out_instr and out_pc are 0 while the FIFO is empty.
- **RUN, fetch rule:** the unit fetches when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
- **RUN, fetch of a nonzero word:** {pc, imem_instr} is pushed and pc<=pc+4. The PC wraps modulo 2^32.
- **RUN, fetch of 32'h0000_0000:** nothing is pushed, pc holds, and the state moves to HALT. Entries already in the FIFO still drain.
- **HALT:** no fetches; pc holds; halted=1.
- **Pop:** a pop happens when out_valid && out_ready. Push and pop can occur in the same cycle; count is then unchanged.
- **Redirect, aligned target** (redirect_valid with redirect_pc[1:0]==0), from RUN or HALT:
  - the FIFO is flushed (count<=0) and pc<=redirect_pc;
  - the state becomes RUN;
  - no push happens in that cycle.
- **Redirect, misaligned target** (redirect_pc[1:0]!=0):
  - the FIFO is flushed and pc holds;
  - the state becomes ERR.
- **ERR:** terminal until rst; misalign_err=1; no fetches; redirects are ignored.
- **Precedence:** rst > redirect > pop/push.
- **Output in the redirect cycle:** out_valid is forced to 0 combinationally, so no handshake completes in that cycle.

## Timing
- Fetch-to-output latency is 1 cycle. A word fetched in cycle N appears at the FIFO head in cycle N+1, provided the FIFO was empty.
- After rst is released in cycle 0: fetch of RESET_PC happens in cycle 1, and out_valid=1 with out_pc=RESET_PC in cycle 2.
- Throughput is one instruction per cycle while out_ready stays high.
- With out_ready low, the FIFO fills after DEPTH fetches, then pc stalls. No entry is lost or duplicated.
- After a redirect in cycle N, the target is fetched in cycle N+1 and is visible in cycle N+2.
- halted and misalign_err are registered and assert the cycle after the triggering event.

## Structure
- The shared package `fetch_pkg` holds:
  - the state encoding (RUN, HALT, ERR);
  - NOP_ZERO = 32'h0;
  - PC_STEP = 4;
  - the fetch_entry_t structure {pc[31:0], instr[31:0]}.
- One sub-module, `fetch_fifo`: a synchronous FIFO of width 64 and depth DEPTH, with push, pop and flush inputs and count, full and empty outputs. Flush has priority over push and pop.

## Test plan
- **Straight-line fetch:** reset, out_ready=1, memory preloaded with addi x1,x0,5 (0x00500093) at address 0x0 and addi x2,x0,10 (0x00A00113) at 0x4.
  - Cycle 2: out_pc=0x0, out_instr=0x00500093.
  - Cycle 3: out_pc=0x4, out_instr=0x00A00113.
- **Backpressure:** hold out_ready=0 for 5 cycles.
  - count settles at 2 and imem_addr stops at 0x8.
  - After release, decode receives PCs 0x0, 0x4, 0x8 with none skipped.
- **Redirect:** assert redirect_valid with redirect_pc=0x34 while the FIFO is full.
  - out_valid=0 in the redirect cycle.
  - Next instruction seen by decode has out_pc=0x34, out_instr=0x04D00613.
- **Halt on zero word:** memory is zero from word 21 (address 0x54).
  - Decode receives the word at 0x50 last; halted=1; imem_addr stays at 0x54.
  - A redirect to 0x0 clears halted, and decode next receives out_pc=0x0.
- **Misaligned redirect:** redirect_pc=0x6.
  - misalign_err=1 the following cycle; out_valid=0; no further fetches.
  - A later redirect to 0x0 is ignored; only rst clears the error.
- **Reset mid-stream:** assert rst with the FIFO holding 2 entries.
  - Next cycle: out_valid=0, imem_addr=RESET_PC.
  - Cycle 2 after release: out_pc=RESET_PC.
